// File: rtl/sync_fifo_param.sv
// Parametrised single-clock valid/ready FIFO with first-word fall-through output,
// fill-level reporting, almost-full/empty flags, synchronous flush and a high-water mark.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 33,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              upstr_d_valid,
  input  logic [DATA_W-1:0] upstr_data,
  output logic              upstr_d_ready,
  output logic              downstr_d_valid,
  output logic [DATA_W-1:0] downstr_data,
  input  logic              downstr_d_ready,
  output logic [CNT_W-1:0]  fill_level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  max_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] max_q, max_d;

  logic full;
  logic push;
  logic pop;

  assign full = (count_q == CNT_W'(DEPTH));

  // Ready is gated by rst so it drops the instant reset asserts, not at the next edge.
  assign upstr_d_ready   = ~full & ~rst;
  assign downstr_d_valid = (count_q != '0);
  assign downstr_data    = mem[rd_ptr_q];

  // A flush cycle discards any handshake presented alongside it.
  assign push = upstr_d_valid & upstr_d_ready & ~flush;
  assign pop  = downstr_d_valid & downstr_d_ready & ~flush;

  assign fill_level   = count_q;
  assign max_level    = max_q;
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    max_d    = max_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      max_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // count never exceeds DEPTH, so the mark saturates there naturally.
      if (count_d > max_q) max_d = count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
    end
  end

  // Storage carries no reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= upstr_data;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a reference count model plus a data scoreboard
// queue, checked with immediate assertions after every clock step.
module tb_sync_fifo_param;

  localparam int unsigned DATA_W = 33;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              up_valid;
  logic [DATA_W-1:0] up_data;
  logic              up_ready;
  logic              dn_valid;
  logic [DATA_W-1:0] dn_data;
  logic              dn_ready;
  logic [CNT_W-1:0]  fill;
  logic              af;
  logic              ae;
  logic [CNT_W-1:0]  maxl;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] sb [$];
  int unsigned mcount = 0;
  int unsigned mmax   = 0;
  bit          in_rst = 1'b1;

  sync_fifo_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_THRESH(14),
    .AE_THRESH(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .upstr_d_valid  (up_valid),
    .upstr_data     (up_data),
    .upstr_d_ready  (up_ready),
    .downstr_d_valid(dn_valid),
    .downstr_data   (dn_data),
    .downstr_d_ready(dn_ready),
    .fill_level     (fill),
    .almost_full    (af),
    .almost_empty   (ae),
    .max_level      (maxl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("up_ready", 64'(up_ready), 64'(!in_rst && mcount < DEPTH));
    check("dn_valid", 64'(dn_valid), 64'(mcount != 0));
    check("fill_level", 64'(fill), 64'(mcount));
    check("almost_full", 64'(af), 64'(mcount >= 14));
    check("almost_empty", 64'(ae), 64'(mcount <= 2));
    check("max_level", 64'(maxl), 64'(mmax));
    if (mcount != 0) check("head_data", 64'(dn_data), 64'(sb[0]));
  endtask

  // One clock: predict handshakes from the model, scoreboard them, advance, re-check.
  task automatic step();
    bit mpush, mpop;
    logic [DATA_W-1:0] exp;
    mpush = up_valid && (mcount < DEPTH) && !flush;
    mpop  = dn_ready && (mcount != 0) && !flush;
    if (mpop) begin
      exp = sb.pop_front();
      check("pop_data", 64'(dn_data), 64'(exp));
    end
    if (mpush) sb.push_back(up_data);
    @(posedge clk);
    #1;
    if (flush) begin
      sb.delete();
      mcount = 0;
      mmax   = 0;
    end else begin
      if (mpush && !mpop) mcount++;
      if (mpop && !mpush) mcount--;
      if (mcount > mmax) mmax = mcount;
    end
    check_state();
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    up_valid = 1'b0;
    up_data  = '0;
    dn_ready = 1'b0;

    // Reset held two cycles, then idle.
    repeat (2) @(posedge clk);
    #1;
    check_state();
    rst    = 1'b0;
    in_rst = 1'b0;
    #1;
    check_state();
    step();

    // Fill with downstream stalled, then one extra beat that must be refused.
    up_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      up_data = DATA_W'(i);
      step();
    end
    up_valid = 1'b0;
    check("max_after_fill", 64'(maxl), 64'(DEPTH));

    // Drain in order in consecutive cycles.
    dn_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    step();
    dn_ready = 1'b0;

    // Prime to 3, then stream 40 random words with push and pop together.
    up_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_data = {1'($urandom_range(1)), 32'($urandom)};
      step();
    end
    dn_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      up_data = {1'($urandom_range(1)), 32'($urandom)};
      step();
    end
    up_valid = 1'b0;
    step();
    step();
    step();
    dn_ready = 1'b0;

    // Backpressure: two words held for 5 stalled cycles, then one pop.
    up_valid = 1'b1;
    up_data  = 33'h1_2345_6789;
    step();
    up_data  = 33'h0_ABCD_EF01;
    step();
    up_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_data = DATA_W'(i * 7 + 3);
      step();
    end
    dn_ready = 1'b1;
    step();
    check("bp_next_word", 64'(dn_data), 64'(33'h0_ABCD_EF01));
    step();
    dn_ready = 1'b0;

    // Flush at count 9 alongside a push; the flushed beat must never surface.
    up_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      up_data = DATA_W'(32'h100 + i);
      step();
    end
    flush   = 1'b1;
    up_data = 33'h1_DEAD_BEEF;
    step();
    flush = 1'b0;
    check("fill_after_flush", 64'(fill), 64'(0));
    check("max_after_flush", 64'(maxl), 64'(0));
    for (int i = 0; i < 5; i++) begin
      up_data = DATA_W'(32'h200 + i);
      step();
    end
    up_valid = 1'b0;
    check("post_flush_head", 64'(dn_data), 64'(33'h200));

    // Async reset pulse between edges: state clears with no clock edge.
    #2;
    rst    = 1'b1;
    in_rst = 1'b1;
    sb.delete();
    mcount = 0;
    mmax   = 0;
    #1;
    check_state();
    #1;
    rst    = 1'b0;
    in_rst = 1'b0;
    #1;
    check_state();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised next-generation synchronous valid/ready FIFO for the upstream-to-downstream data path, replacing the fixed 33-bit FIFO. It adds configurable width and depth, fill-level reporting, almost-full and almost-empty flags, a synchronous flush, and a high-water-mark register for buffer sizing. It has a single clock domain, and both sides use valid/ready handshakes.

Parameters:
DATA_W, 33, payload width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
CNT_W, $clog2(DEPTH+1), width of count outputs (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous clear of contents, active-high
upstr_d_valid  in  1  upstream data valid
upstr_data  in  DATA_W  upstream payload
upstr_d_ready  out  1  FIFO can accept (not full, not in reset)
downstr_d_valid  out  1  FIFO holds data (not empty)
downstr_data  out  DATA_W  head-of-queue payload
downstr_d_ready  in  1  downstream accepts
fill_level  out  CNT_W  current entry count, 0..DEPTH
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
max_level  out  CNT_W  highest fill_level since reset/flush

Behaviour:
- Reset (rst high, asynchronous): wr_ptr, rd_ptr, and count go to 0, and max_level goes to 0. Outputs are upstr_d_ready=0, downstr_d_valid=0, fill_level=0, almost_full=0, almost_empty=1. Storage array is not reset.
- After rst deasserts, upstr_d_ready=1 from the first cycle.
- Push = upstr_d_valid & upstr_d_ready. Pop = downstr_d_valid & downstr_d_ready. Both are sampled at the rising edge of clk.
- upstr_d_ready = !full, driven from registered count. There is no same-cycle pass-through when full: a pop in a full cycle does not enable a push in that same cycle.
- downstr_d_valid = (count != 0). downstr_data = mem[rd_ptr] (first-word fall-through).
- downstr_data is a don't-care when valid is low.
- Latency: a word pushed at edge N gives downstr_d_valid=1 with that data after edge N (1 cycle). There is no empty bypass.
- Output stability: while downstr_d_valid=1 and downstr_d_ready=0, downstr_data and valid hold steady.
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, but both pointers advance
- Count never exceeds DEPTH and never goes below 0. Handshake gating makes overflow and underflow impossible.
- fill_level = count, registered. almost_full and almost_empty are combinational from registered count.
- max_level:
  - updates to the next count whenever next count > max_level
  - saturates at DEPTH
- Flush (synchronous, highest non-reset priority):
  - pointers, count, and max_level go to 0 at the edge
  - any push or pop presented in the flush cycle is discarded, with no data transfer
  - upstr_d_ready stays combinationally valid for the flush cycle, but the upstream must treat that cycle's beat as dropped
  - downstr_d_valid=0 the cycle after flush
- Reset asserted mid-transfer: state clears immediately, without waiting for a clock. In-flight data is lost.
- Upstream may change upstr_data every cycle. Only the value at a push edge is stored.

Test Plan:
- Reset then idle, DEPTH=16: hold rst high 2 cycles, then release -> upstr_d_ready=1, downstr_d_valid=0, fill_level=0, almost_empty=1, almost_full=0, max_level=0.
- Fill with downstr_d_ready=0: push 0x0_0000_0001..0x0_0000_0010 -> fill_level reaches 16. almost_full rises at count 14. upstr_d_ready=0 after the 16th push. A 17th valid beat is not stored. max_level=16.
- Drain in order after the fill: assert downstr_d_ready -> downstr_data sequence is 0x1..0x10 in 16 consecutive cycles. downstr_d_valid drops after the last. almost_empty rises at count 2.
- Streaming with wrap: continuous push and pop of 40 random words at count 3 -> fill_level stays 3. Output order matches input order across 2+ pointer wraps.
- Backpressure stability: stall downstream 5 cycles with data present -> downstr_data and valid are unchanged. Release -> the next word appears after one pop edge.
- Flush and async reset: with count=9, flush one cycle alongside a push -> fill_level=0, max_level=0, the pushed word is never output. Then with count=5, pulse rst between clock edges -> fill_level=0 and upstr_d_ready=0 immediately, without waiting for a clock edge.
